cmd_exec_injector: RTL and testbench

- Downstream of the /CMD block loader; consumes its download flag and its execute address/enable pulse.
- Holds the Z80 while a download is in progress.
- After the download ends, if a transfer (type 2) block supplied an entry address, forces the CPU to that address. It does this by substituting a 3-byte JP nn (C3 lo hi) on the next opcode fetch and the two operand reads that follow.
- The top level muxes inject_data onto the CPU data-in bus in place of RAM data.

---
 rtl/cmd_exec_injector.sv | 180 ++++++++++++++++++
 tb/tb_cmd_exec_injector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_exec_injector.sv
// Holds the Z80 during a /CMD download, then forces a JP to the loaded entry
// address by substituting C3 lo hi on the next opcode fetch and two operand reads.
module cmd_exec_injector #(
    parameter int          ADDR    = 16,
    parameter logic [23:0] TIMEOUT = 24'd4000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            loader_download,
    input  logic [ADDR-1:0] execute_addr,
    input  logic            execute_enable,
    input  logic            cpu_m1_n,
    input  logic            cpu_mreq_n,
    input  logic            cpu_rd_n,
    output logic            cpu_hold,
    output logic            inject_active,
    output logic [7:0]      inject_data,
    output logic            exec_done,
    output logic            exec_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADING,
        S_WAIT_M1,
        S_INJ_OP,
        S_INJ_LO,
        S_INJ_HI
    } state_t;

    state_t      state_q, state_d;
    logic        dl_q;
    logic        rd_cyc_q;
    logic [15:0] exec_addr_q, exec_addr_d;
    logic        exec_pending_q, exec_pending_d;
    logic [23:0] count_q, count_d;

    logic        cpu_hold_q, cpu_hold_d;
    logic        inject_active_q, inject_active_d;
    logic [7:0]  inject_data_q, inject_data_d;
    logic        exec_done_q, exec_done_d;
    logic        exec_timeout_q, exec_timeout_d;

    logic rd_cyc;
    logic fetch_start;
    logic rd_end;
    logic dl_rise;
    logic dl_fall;

    assign rd_cyc      = ~cpu_mreq_n & ~cpu_rd_n;
    assign fetch_start = rd_cyc & ~rd_cyc_q & ~cpu_m1_n;
    assign rd_end      = rd_cyc_q & ~rd_cyc;
    assign dl_rise     = loader_download & ~dl_q;
    assign dl_fall     = ~loader_download & dl_q;

    always_comb begin
        state_d        = state_q;
        exec_addr_d    = exec_addr_q;
        exec_pending_d = exec_pending_q;
        count_d        = count_q;
        exec_done_d    = 1'b0;
        exec_timeout_d = 1'b0;

        // A fresh download always wins: it starts loading and aborts any
        // pending injection without signalling done or timeout.
        if (dl_rise) begin
            state_d        = S_LOADING;
            exec_pending_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOADING: begin
                    if (dl_fall) begin
                        if (exec_pending_q || execute_enable) begin
                            state_d = S_WAIT_M1;
                            count_d = 24'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_WAIT_M1: begin
                    if (fetch_start) begin
                        state_d = S_INJ_OP;
                    end else if (count_q >= TIMEOUT - 24'd1) begin
                        state_d        = S_IDLE;
                        exec_timeout_d = 1'b1;
                        exec_pending_d = 1'b0;
                    end else if (count_q != 24'hFF_FFFF) begin
                        count_d = count_q + 24'd1;
                    end
                end
                S_INJ_OP: begin
                    if (rd_end) state_d = S_INJ_LO;
                end
                S_INJ_LO: begin
                    if (rd_end) state_d = S_INJ_HI;
                end
                S_INJ_HI: begin
                    if (rd_end) begin
                        state_d        = S_IDLE;
                        exec_done_d    = 1'b1;
                        exec_pending_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Entry address latch is independent of state; last pulse wins.
        if (execute_enable) begin
            exec_addr_d    = execute_addr[15:0];
            exec_pending_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        cpu_hold_d      = (state_d == S_LOADING);
        inject_active_d = 1'b0;
        inject_data_d   = 8'h00;
        unique case (state_d)
            S_INJ_OP: begin
                inject_active_d = 1'b1;
                inject_data_d   = 8'hC3;
            end
            S_INJ_LO: begin
                inject_active_d = 1'b1;
                inject_data_d   = exec_addr_d[7:0];
            end
            S_INJ_HI: begin
                inject_active_d = 1'b1;
                inject_data_d   = exec_addr_d[15:8];
            end
            default: begin
                inject_active_d = 1'b0;
                inject_data_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            dl_q            <= 1'b0;
            rd_cyc_q        <= 1'b0;
            exec_addr_q     <= 16'h0000;
            exec_pending_q  <= 1'b0;
            count_q         <= 24'd0;
            cpu_hold_q      <= 1'b0;
            inject_active_q <= 1'b0;
            inject_data_q   <= 8'h00;
            exec_done_q     <= 1'b0;
            exec_timeout_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            dl_q            <= loader_download;
            rd_cyc_q        <= rd_cyc;
            exec_addr_q     <= exec_addr_d;
            exec_pending_q  <= exec_pending_d;
            count_q         <= count_d;
            cpu_hold_q      <= cpu_hold_d;
            inject_active_q <= inject_active_d;
            inject_data_q   <= inject_data_d;
            exec_done_q     <= exec_done_d;
            exec_timeout_q  <= exec_timeout_d;
        end
    end

    assign cpu_hold      = cpu_hold_q;
    assign inject_active = inject_active_q;
    assign inject_data   = inject_data_q;
    assign exec_done     = exec_done_q;
    assign exec_timeout  = exec_timeout_q;

endmodule

// File: tb/tb_cmd_exec_injector.sv
// Directed vector bench for cmd_exec_injector: each row drives one clock of
// inputs and lists the outputs expected just after that clock edge.
module tb_cmd_exec_injector;

    logic        clock;
    logic        reset;
    logic        loader_download;
    logic [15:0] execute_addr;
    logic        execute_enable;
    logic        cpu_m1_n;
    logic        cpu_mreq_n;
    logic        cpu_rd_n;
    logic        cpu_hold;
    logic        inject_active;
    logic [7:0]  inject_data;
    logic        exec_done;
    logic        exec_timeout;

    int n_checks = 0;
    int n_err    = 0;
    int row_no   = 0;

    // {m1_n, mreq_n, rd_n}
    localparam logic [2:0] B_IDLE  = 3'b111;
    localparam logic [2:0] B_FETCH = 3'b000;
    localparam logic [2:0] B_READ  = 3'b100;
    localparam logic [2:0] B_WRITE = 3'b101;
    localparam logic [2:0] B_IO    = 3'b110;

    typedef struct {
        logic        dl;
        logic        en;
        logic [15:0] addr;
        logic [2:0]  bus;
        logic        hold;
        logic        act;
        logic [7:0]  data;
        logic        done;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    cmd_exec_injector #(
        .ADDR   (16),
        .TIMEOUT(24'd100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .loader_download(loader_download),
        .execute_addr   (execute_addr),
        .execute_enable (execute_enable),
        .cpu_m1_n       (cpu_m1_n),
        .cpu_mreq_n     (cpu_mreq_n),
        .cpu_rd_n       (cpu_rd_n),
        .cpu_hold       (cpu_hold),
        .inject_active  (inject_active),
        .inject_data    (inject_data),
        .exec_done      (exec_done),
        .exec_timeout   (exec_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic dl, input logic en, input logic [15:0] addr,
                                input logic [2:0] bus, input logic hold, input logic act,
                                input logic [7:0] data, input logic done, input logic to);
        vec_t v;
        v.dl = dl; v.en = en; v.addr = addr; v.bus = bus;
        v.hold = hold; v.act = act; v.data = data; v.done = done; v.to = to;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %02h expected %02h", name, row_no, got, exp);
        end
    endtask

    task automatic check_outputs(input logic hold, input logic act, input logic [7:0] data,
                                 input logic done, input logic to);
        check("cpu_hold",      {7'd0, cpu_hold},      {7'd0, hold});
        check("inject_active", {7'd0, inject_active}, {7'd0, act});
        check("inject_data",   inject_data,           data);
        check("exec_done",     {7'd0, exec_done},     {7'd0, done});
        check("exec_timeout",  {7'd0, exec_timeout},  {7'd0, to});
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        loader_download = v.dl;
        execute_enable  = v.en;
        execute_addr    = v.addr;
        {cpu_m1_n, cpu_mreq_n, cpu_rd_n} = v.bus;
        @(posedge clock);
        #1;
        check_outputs(v.hold, v.act, v.data, v.done, v.to);
        $display("row %0d: dl=%0b en=%0b addr=%04h bus=%03b -> hold=%0b act=%0b data=%02h done=%0b to=%0b",
                 row_no, v.dl, v.en, v.addr, v.bus, cpu_hold, inject_active, inject_data,
                 exec_done, exec_timeout);
        row_no++;
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic async_reset_check();
        #2;
        reset = 1'b1;
        #1;
        check_outputs(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        $display("row %0d: async reset -> hold=%0b act=%0b data=%02h", row_no, cpu_hold,
                 inject_active, inject_data);
        row_no++;
        @(negedge clock);
        loader_download = 1'b0;
        execute_enable  = 1'b0;
        execute_addr    = 16'h0000;
        {cpu_m1_n, cpu_mreq_n, cpu_rd_n} = B_IDLE;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        loader_download = 1'b0;
        execute_enable  = 1'b0;
        execute_addr    = 16'h0000;
        {cpu_m1_n, cpu_mreq_n, cpu_rd_n} = B_IDLE;

        // Download with 5200, write and I/O cycles must not advance injection.
        tbl.push_back(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 16'h5200, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_WRITE, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IO,    0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h52, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h52, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h52, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        // Download without an entry address: no injection follows.
        tbl.push_back(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_FETCH, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_FETCH, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        // Two entry pulses: the later one (7000) wins.
        tbl.push_back(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 16'h4000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 16'h7000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h70, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h70, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h70, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        // Entry pulse on the falling edge of download; a non-M1 read is not a fetch.
        tbl.push_back(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 16'h6A10, B_IDLE,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h10, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h10, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h10, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h6A, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h6A, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h6A, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_outputs(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        $display("row %0d: in reset -> hold=%0b act=%0b data=%02h", row_no, cpu_hold,
                 inject_active, inject_data);
        row_no++;
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Timeout: no fetch after the download, pulse exactly 100 clocks later.
        apply(mk(1, 0, 16'h0000, B_IDLE, 1, 0, 8'h00, 0, 0));
        apply(mk(1, 1, 16'h1234, B_IDLE, 1, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE, 0, 0, 8'h00, 0, 0));
        for (int k = 1; k <= 100; k++)
            apply(mk(0, 0, 16'h0000, B_IDLE, 0, 0, 8'h00, 0, (k == 100)));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));

        // Download restart during INJ_OP, then a clean jump to 6000.
        apply(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        apply(mk(1, 1, 16'h5200, B_IDLE,  1, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        apply(mk(1, 0, 16'h0000, B_FETCH, 1, 0, 8'h00, 0, 0));
        apply(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        apply(mk(1, 1, 16'h6000, B_IDLE,  1, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h60, 0, 0));
        apply(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h60, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 1, 0));

        // Reset in the middle of INJ_LO with 5200 latched.
        apply(mk(1, 0, 16'h0000, B_IDLE,  1, 0, 8'h00, 0, 0));
        apply(mk(1, 1, 16'h5200, B_IDLE,  1, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 1, 8'hC3, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 1, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_READ,  0, 1, 8'h00, 0, 0));
        async_reset_check();
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));

        // Reset while holding the CPU in LOADING.
        apply(mk(1, 1, 16'h3456, B_IDLE,  1, 0, 8'h00, 0, 0));
        async_reset_check();
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_FETCH, 0, 0, 8'h00, 0, 0));
        apply(mk(0, 0, 16'h0000, B_IDLE,  0, 0, 8'h00, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
